reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter START_ADDR, default 0, first register index dumped.
REQ-002 Parameter END_ADDR, default 31, last register index dumped; legal only when START_ADDR <= END_ADDR <= 31.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a dump, sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a dump in progress.
REQ-007 rAddr  output  5  read address driven to the register file read port.
REQ-008 rDin  input  32  combinational read data returned for rAddr.
REQ-009 wEna  input  1  register file write enable, snooped.
REQ-010 wAddr  input  5  register file write address, snooped.
REQ-011 wDin  input  32  register file write data, snooped.
REQ-012 dout_valid  output  1  dump word available.
REQ-013 dout_ready  input  1  consumer accepts the word when high with dout_valid.
REQ-014 dout_data  output  32  captured register value.
REQ-015 dout_addr  output  5  index of the register in dout_data.
REQ-016 dout_last  output  1  high with dout_valid for the END_ADDR word only.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse marking completion of a full dump.

Function
REQ-019 The FSM SHALL have states IDLE, CAPTURE, SEND, and DONE.
REQ-020 In IDLE with start=1 and abort=0, the next state SHALL be CAPTURE, and the index SHALL load START_ADDR.
REQ-021 rAddr SHALL equal the current index in all states.
REQ-022 In CAPTURE, the block SHALL latch dout_data and dout_addr from rDin and the index, then go to SEND; CAPTURE always lasts exactly one cycle.
REQ-023 Snoop bypass: if wEna=1 and wAddr equals the index in the CAPTURE cycle, the block SHALL latch wDin instead of rDin.
REQ-024 The snoop bypass SHALL NOT apply when wAddr=0; rDin is captured for register 0 in all cases.
REQ-025 dout_valid SHALL be high exactly in SEND.
REQ-026 dout_data, dout_addr, and dout_last SHALL stay stable while dout_valid=1 and dout_ready=0; writes in SEND do not alter the held word.
REQ-027 On a SEND handshake with index < END_ADDR, the index SHALL increment by 1 and the next state SHALL be CAPTURE.
REQ-028 On a SEND handshake with index = END_ADDR, the next state SHALL be DONE; the index never wraps past 31.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 Latency: with dout_ready held at 1, the first dout_valid SHALL occur 2 cycles after the start edge, with one word every 2 cycles after that.
REQ-031 A full dump with dout_ready held at 1 SHALL take 2*(END_ADDR-START_ADDR+1)+1 cycles from leaving IDLE to re-entering IDLE.
REQ-032 start SHALL be ignored outside IDLE.
REQ-033 If start and abort are both high in IDLE, the block SHALL remain in IDLE.
REQ-034 abort=1 in CAPTURE, SEND, or DONE SHALL force IDLE at the next edge.
REQ-035 On abort, dout_valid SHALL drop at that edge even without a handshake; done is not pulsed, and an abort in DONE suppresses the pulse.
REQ-036 Abort SHALL take priority over a coincident handshake.
REQ-037 Each word is a per-register snapshot taken at its CAPTURE cycle; the dump as a whole is not atomic.

Reset
REQ-038 While rst_n=0, the block SHALL immediately enter IDLE with index=0, rAddr=0, dout_valid=0, dout_data=0, dout_addr=0, dout_last=0, busy=0, and done=0.
REQ-039 Reset asserted mid-dump SHALL abandon the dump without a done pulse.
REQ-040 After rst_n deasserts, the block SHALL need a fresh start to begin a dump.

Verification
REQ-041 Scenario 1: regs preloaded r[n]=n*0x11, start pulse, dout_ready=1 -> 32 words, addr 0..31, data n*0x11, dout_last only on addr 31, done pulse at cycle 65 after start.
REQ-042 Scenario 2: dout_ready=0 for 5 cycles on word addr 3 -> valid held, data 0x33 and addr 3 stable, addr 4 follows 2 cycles after ready rises.
REQ-043 Scenario 3: in the CAPTURE cycle for addr 7, wEna=1, wAddr=7, wDin=0xDEADBEEF -> word 7 = 0xDEADBEEF.
REQ-044 Scenario 4: same stimulus with wAddr=0 during the addr 0 capture -> word 0 = 0.
REQ-045 Scenario 5: abort while SEND for addr 10 with dout_ready=1 -> next cycle IDLE, busy=0, no addr 11 word, no done pulse.
REQ-046 Scenario 6: START_ADDR=29, END_ADDR=31, rst_n pulsed low while word 30 is pending -> outputs zero asynchronously; a subsequent start yields words 29, 30, 31 then done.
REQ-047 Scenario 7: start pulses while busy -> no restart and index unaffected.
REQ-048 Scenario 8: start and abort high together in IDLE -> block stays IDLE.

Source files
------------

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: streams a register range over a valid/ready port,
// snooping the write port so each word matches its capture cycle.
module reg_dump_ctrl #(
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rAddr,
  input  logic [31:0] rDin,
  input  logic        wEna,
  input  logic [4:0]  wAddr,
  input  logic [31:0] wDin,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic [4:0]  dout_addr,
  output logic        dout_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST = 5'(START_ADDR);
  localparam logic [4:0] LAST  = 5'(END_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      stateNxt;
  logic [4:0]  idx;
  logic [4:0]  idxNxt;
  logic [31:0] dataQ;
  logic [4:0]  addrQ;
  logic        lastQ;
  logic        capEn;
  logic        bypass;
  logic        isLast;

  assign isLast = (idx == LAST);

  // r0 is hardwired, so a write aimed at it never reaches the snapshot
  assign bypass = wEna && (wAddr == idx) && (wAddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    idxNxt   = idx;
    capEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          stateNxt = CAPTURE;
          idxNxt   = FIRST;
        end
      end
      CAPTURE: begin
        if (abort) begin
          stateNxt = IDLE;
        end else begin
          capEn    = 1'b1;
          stateNxt = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          stateNxt = IDLE;
        end else if (dout_ready) begin
          if (isLast) begin
            stateNxt = DONE;
          end else begin
            stateNxt = CAPTURE;
            idxNxt   = idx + 5'd1;
          end
        end
      end
      DONE: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataQ <= '0;
      addrQ <= '0;
      lastQ <= 1'b0;
    end else if (capEn) begin
      dataQ <= bypass ? wDin : rDin;
      addrQ <= idx;
      lastQ <= isLast;
    end
  end

  assign rAddr      = idx;
  assign dout_valid = (state == SEND);
  assign dout_data  = dataQ;
  assign dout_addr  = addrQ;
  assign dout_last  = (state == SEND) && lastQ;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !abort;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb_reg_dump_ctrl: two instances (full range and 29..31) against a
// step-count model, plus directed scenarios with literal expectations.
module tb_reg_dump_ctrl;

  localparam int S0 = 0;
  localparam int E0 = 31;
  localparam int S1 = 29;
  localparam int E1 = 31;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        wEna;
  logic [4:0]  wAddr;
  logic [31:0] wDin;
  logic        dout_ready;

  logic [4:0]  rAddr [2];
  logic [31:0] rDin [2];
  logic        dout_valid [2];
  logic [31:0] dout_data [2];
  logic [4:0]  dout_addr [2];
  logic        dout_last [2];
  logic        busy [2];
  logic        done [2];

  logic [31:0] rf [32];

  int          mStep [2];
  int          mIdx [2];
  logic [31:0] mData [2];
  logic [4:0]  mAddr [2];

  word_t q0[$];
  word_t q1[$];
  int    doneCnt [2];
  int    nChk = 0;
  int    nFail = 0;
  int    cmpN;
  int    cmpSt;
  bit    cmpV;

  assign rDin[0] = rf[rAddr[0]];
  assign rDin[1] = rf[rAddr[1]];

  always #5 clk = ~clk;

  reg_dump_ctrl #(.START_ADDR(S0), .END_ADDR(E0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rAddr(rAddr[0]), .rDin(rDin[0]),
    .wEna(wEna), .wAddr(wAddr), .wDin(wDin),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready),
    .dout_data(dout_data[0]), .dout_addr(dout_addr[0]),
    .dout_last(dout_last[0]), .busy(busy[0]), .done(done[0])
  );

  reg_dump_ctrl #(.START_ADDR(S1), .END_ADDR(E1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rAddr(rAddr[1]), .rDin(rDin[1]),
    .wEna(wEna), .wAddr(wAddr), .wDin(wDin),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready),
    .dout_data(dout_data[1]), .dout_addr(dout_addr[1]),
    .dout_last(dout_last[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int sOf(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int eOf(input int i);
    return (i == 0) ? E0 : E1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Step k of a dump: even = snapshot of word k/2, odd = word k/2 offered,
  // 2n = completion cycle; -1 = not dumping.
  task automatic modelStep(input int i);
    int n;
    int st;
    n  = eOf(i) - sOf(i) + 1;
    st = mStep[i];
    if (st < 0) begin
      if (start && !abort) begin
        mStep[i] = 0;
        mIdx[i]  = sOf(i);
      end
    end else if (abort || st == 2 * n) begin
      mStep[i] = -1;
    end else if (st % 2 == 0) begin
      if (wEna && wAddr == 5'(mIdx[i]) && wAddr != 5'd0) mData[i] = wDin;
      else mData[i] = rf[mIdx[i]];
      mAddr[i] = 5'(mIdx[i]);
      mStep[i] = st + 1;
    end else if (dout_ready) begin
      mStep[i] = st + 1;
      if (st + 1 < 2 * n) mIdx[i] = sOf(i) + (st + 1) / 2;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mStep[i] = -1;
        mIdx[i]  = 0;
        mData[i] = '0;
        mAddr[i] = '0;
      end
      for (int r = 0; r < 32; r++) rf[r] <= 32'(r * 32'h11);
    end else begin
      for (int i = 0; i < 2; i++) modelStep(i);
      if (wEna && wAddr != 5'd0) rf[wAddr] <= wDin;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cmpN  = eOf(i) - sOf(i) + 1;
        cmpSt = mStep[i];
        cmpV  = (cmpSt >= 0) && (cmpSt % 2 == 1);
        check($sformatf("busy%0d", i), 32'(busy[i]), 32'(cmpSt >= 0));
        check($sformatf("valid%0d", i), 32'(dout_valid[i]), 32'(cmpV));
        check($sformatf("done%0d", i), 32'(done[i]),
              32'(cmpSt == 2 * cmpN && !abort));
        check($sformatf("last%0d", i), 32'(dout_last[i]),
              32'(cmpV && mAddr[i] == 5'(eOf(i))));
        check($sformatf("rAddr%0d", i), 32'(rAddr[i]), 32'(mIdx[i]));
        check($sformatf("daddr%0d", i), 32'(dout_addr[i]), 32'(mAddr[i]));
        check($sformatf("ddata%0d", i), dout_data[i], mData[i]);
        if (done[i]) doneCnt[i]++;
      end
      if (dout_valid[0] && dout_ready && !abort)
        q0.push_back('{dout_addr[0], dout_data[0], dout_last[0]});
      if (dout_valid[1] && dout_ready && !abort)
        q1.push_back('{dout_addr[1], dout_data[1], dout_last[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearMon();
    q0.delete();
    q1.delete();
    doneCnt[0] = 0;
    doneCnt[1] = 0;
  endtask

  task automatic waitCap(input int i, input int a, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (busy[i] && !dout_valid[i] && !done[i] && rAddr[i] == 5'(a)) ok = 1'b1;
      else tick();
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  task automatic waitSend(input int i, input int a, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (dout_valid[i] && dout_addr[i] == 5'(a)) ok = 1'b1;
      else tick();
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  task automatic waitIdle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (!busy[0] && !busy[1]) ok = 1'b1;
      else tick();
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit found;
    start      = 1'b0;
    abort      = 1'b0;
    wEna       = 1'b0;
    wAddr      = '0;
    wDin       = '0;
    dout_ready = 1'b1;
    doneCnt[0] = 0;
    doneCnt[1] = 0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #11;
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_valid", 32'(dout_valid[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_rAddr", 32'(rAddr[0]), 32'd0);
    check("rst_data", dout_data[0], 32'd0);
    check("rst_addr", 32'(dout_addr[0]), 32'd0);
    check("rst_last", 32'(dout_last[0]), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // full dump, ready held high
    clearMon();
    pulseStart();
    cnt   = 1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (done[0]) found = 1'b1;
      else begin
        @(posedge clk);
        #2;
        cnt++;
      end
    end
    check("s1_done_seen", 32'(found), 32'd1);
    check("s1_done_cycle", 32'(cnt), 32'd65);
    tick();
    waitIdle("s1_idle");
    check("s1_words", 32'(q0.size()), 32'd32);
    for (int k = 0; k < 32 && k < q0.size(); k++) begin
      check($sformatf("s1_a%0d", k), 32'(q0[k].a), 32'(k));
      check($sformatf("s1_d%0d", k), q0[k].d, 32'(k * 32'h11));
      check($sformatf("s1_l%0d", k), 32'(q0[k].l), 32'(k == 31));
    end
    check("s1_donecnt", 32'(doneCnt[0]), 32'd1);
    check("s1_words1", 32'(q1.size()), 32'd3);

    // back-pressure on word 3, with a write to r3 while it is held
    clearMon();
    pulseStart();
    waitCap(0, 3, "s2_cap3");
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        wEna  = 1'b1;
        wAddr = 5'd3;
        wDin  = 32'h1234_5678;
      end
      tick();
      wEna = 1'b0;
      check("s2_hold_valid", 32'(dout_valid[0]), 32'd1);
      check("s2_hold_addr", 32'(dout_addr[0]), 32'd3);
      check("s2_hold_data", dout_data[0], 32'h33);
    end
    dout_ready = 1'b1;
    tick();
    check("s2_gap", 32'(dout_valid[0]), 32'd0);
    tick();
    check("s2_next_valid", 32'(dout_valid[0]), 32'd1);
    check("s2_next_addr", 32'(dout_addr[0]), 32'd4);
    waitIdle("s2_idle");
    check("s2_words", 32'(q0.size()), 32'd32);
    if (q0.size() > 3) check("s2_w3", q0[3].d, 32'h33);

    // snoop bypass on r7, no bypass on r0
    clearMon();
    pulseStart();
    wEna  = 1'b1;
    wAddr = 5'd0;
    wDin  = 32'hDEAD_BEEF;
    tick();
    wEna = 1'b0;
    waitCap(0, 7, "s3_cap7");
    wEna  = 1'b1;
    wAddr = 5'd7;
    wDin  = 32'hDEAD_BEEF;
    tick();
    wEna = 1'b0;
    waitIdle("s3_idle");
    check("s3_words", 32'(q0.size()), 32'd32);
    if (q0.size() > 8) begin
      check("s4_w0", q0[0].d, 32'h0);
      check("s3_w7", q0[7].d, 32'hDEAD_BEEF);
      check("s3_w8", q0[8].d, 32'h88);
    end

    // abort while word 10 is offered
    clearMon();
    pulseStart();
    waitSend(0, 10, "s5_send10");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s5_busy", 32'(busy[0]), 32'd0);
    check("s5_valid", 32'(dout_valid[0]), 32'd0);
    for (int k = 0; k < 8; k++) tick();
    check("s5_words", 32'(q0.size()), 32'd10);
    if (q0.size() > 0) check("s5_lastaddr", 32'(q0[$].a), 32'd9);
    check("s5_donecnt", 32'(doneCnt[0]), 32'd0);

    // start held while busy
    clearMon();
    pulseStart();
    waitSend(0, 5, "s7_send5");
    start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    start = 1'b0;
    check("s7_rAddr", 32'(rAddr[0]), 32'd7);
    waitIdle("s7_idle");
    check("s7_words", 32'(q0.size()), 32'd32);
    for (int k = 0; k < 32 && k < q0.size(); k++)
      check($sformatf("s7_a%0d", k), 32'(q0[k].a), 32'(k));
    check("s7_donecnt", 32'(doneCnt[0]), 32'd1);

    // start and abort together in idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("s8_busy0", 32'(busy[0]), 32'd0);
    check("s8_busy1", 32'(busy[1]), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("s8_still_idle", 32'(busy[0]), 32'd0);

    // reset while word 30 is pending on the short-range instance
    clearMon();
    pulseStart();
    waitCap(1, 30, "s6_cap30");
    dout_ready = 1'b0;
    tick();
    check("s6_pend_valid", 32'(dout_valid[1]), 32'd1);
    check("s6_pend_addr", 32'(dout_addr[1]), 32'd30);
    #1 rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(dout_valid[1]), 32'd0);
    check("s6_rst_busy", 32'(busy[1]), 32'd0);
    check("s6_rst_data", dout_data[1], 32'd0);
    check("s6_rst_addr", 32'(dout_addr[1]), 32'd0);
    check("s6_rst_rAddr", 32'(rAddr[1]), 32'd0);
    check("s6_rst_last", 32'(dout_last[1]), 32'd0);
    #3 rst_n = 1'b1;
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("s6_need_start", 32'(busy[1]), 32'd0);
    check("s6_no_done", 32'(doneCnt[1]), 32'd0);
    clearMon();
    pulseStart();
    waitIdle("s6_idle");
    check("s6_words", 32'(q1.size()), 32'd3);
    for (int k = 0; k < 3 && k < q1.size(); k++) begin
      check($sformatf("s6_a%0d", k), 32'(q1[k].a), 32'(29 + k));
      check($sformatf("s6_d%0d", k), q1[k].d, 32'((29 + k) * 32'h11));
      check($sformatf("s6_l%0d", k), 32'(q1[k].l), 32'(k == 2));
    end
    check("s6_donecnt", 32'(doneCnt[1]), 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
